// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Round-robin CPU/DMA arbiter feeding the UART transmit FIFO,
//             with FIFO flush sequencing and the 16x baud tick generator.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             wb_rst_ni,
  input  logic             req_a_i,
  input  logic [7:0]       dat_a_i,
  output logic             ack_a_o,
  input  logic             req_b_i,
  input  logic [7:0]       dat_b_i,
  output logic             ack_b_o,
  input  logic [CNT_W-1:0] tf_count_i,
  output logic             tf_push_o,
  output logic [7:0]       tf_dat_o,
  input  logic             flush_i,
  output logic             tx_reset_o,
  input  logic [15:0]      dl_i,
  input  logic             dl_we_i,
  output logic             enable_o,
  output logic             busy_o
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_PUSH   = 2'd1;
  localparam logic [1:0] c_SETTLE = 2'd2;
  localparam logic [1:0] c_FLUSH  = 2'd3;

  // One extra bit so the depth itself is representable for any CNT_W.
  localparam logic [CNT_W:0] c_DEPTH = FIFO_DEPTH[CNT_W:0];

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        r_win_b;
  logic        r_last_b;
  logic [7:0]  r_dat;
  logic        w_pick_b;
  logic        w_room;
  logic        w_admit;
  logic        w_win_req;
  logic        w_push;
  logic [15:0] r_cnt;
  logic        r_en;
  logic        r_run;

  // On a tie the requester that was not granted last wins.
  assign w_pick_b  = req_b_i & (~req_a_i | ~r_last_b);
  assign w_room    = {1'b0, tf_count_i} < c_DEPTH;
  assign w_admit   = (req_a_i | req_b_i) & w_room;
  assign w_win_req = r_win_b ? req_b_i : req_a_i;
  // A winner that withdrew its request is not served and not acked.
  assign w_push    = (r_state == c_PUSH) & w_win_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (flush_i)      w_next = c_FLUSH;
        else if (w_admit) w_next = c_PUSH;
      end
      c_PUSH:   w_next = flush_i ? c_FLUSH : c_SETTLE;
      c_SETTLE: w_next = flush_i ? c_FLUSH : c_IDLE;
      c_FLUSH:  w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= c_IDLE;
      r_win_b  <= 1'b0;
      r_last_b <= 1'b1;
      r_dat    <= 8'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == c_IDLE) && !flush_i && w_admit) begin
        r_win_b <= w_pick_b;
        r_dat   <= w_pick_b ? dat_b_i : dat_a_i;
      end
      if (w_push) begin
        r_last_b <= r_win_b;
      end
    end
  end

  assign tf_push_o  = w_push;
  assign tf_dat_o   = r_dat;
  assign ack_a_o    = w_push & ~r_win_b;
  assign ack_b_o    = w_push &  r_win_b;
  assign tx_reset_o = (r_state == c_FLUSH);
  assign busy_o     = (r_state != c_IDLE);

  // The first active edge after reset behaves like a divisor write.
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cnt <= 16'd0;
      r_en  <= 1'b0;
      r_run <= 1'b0;
    end else if (dl_i == 16'd0) begin
      r_cnt <= 16'd0;
      r_en  <= 1'b0;
    end else if (dl_we_i || !r_run) begin
      r_cnt <= dl_i - 16'd1;
      r_en  <= 1'b0;
      r_run <= 1'b1;
    end else if (r_cnt == 16'd0) begin
      r_cnt <= dl_i - 16'd1;
      r_en  <= 1'b1;
    end else begin
      r_cnt <= r_cnt - 16'd1;
      r_en  <= 1'b0;
    end
  end

  assign enable_o = r_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Brief    : Directed self-checking bench for uart_tx_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        wb_rst_ni;
  logic        req_a_i, req_b_i;
  logic [7:0]  dat_a_i, dat_b_i;
  logic        ack_a_o, ack_b_o;
  logic [4:0]  tf_count_i;
  logic        tf_push_o;
  logic [7:0]  tf_dat_o;
  logic        flush_i;
  logic        tx_reset_o;
  logic [15:0] dl_i;
  logic        dl_we_i;
  logic        enable_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.FIFO_DEPTH(16), .CNT_W(5)) dut (
    .clk        (clk),
    .wb_rst_ni  (wb_rst_ni),
    .req_a_i    (req_a_i),
    .dat_a_i    (dat_a_i),
    .ack_a_o    (ack_a_o),
    .req_b_i    (req_b_i),
    .dat_b_i    (dat_b_i),
    .ack_b_o    (ack_b_o),
    .tf_count_i (tf_count_i),
    .tf_push_o  (tf_push_o),
    .tf_dat_o   (tf_dat_o),
    .flush_i    (flush_i),
    .tx_reset_o (tx_reset_o),
    .dl_i       (dl_i),
    .dl_we_i    (dl_we_i),
    .enable_o   (enable_o),
    .busy_o     (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {push, ack_a, ack_b, busy}
  function automatic logic [3:0] hs();
    return {tf_push_o, ack_a_o, ack_b_o, busy_o};
  endfunction

  function automatic logic [13:0] all_out();
    return {tf_push_o, ack_a_o, ack_b_o, tx_reset_o, busy_o, enable_o, tf_dat_o};
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  exp_hs;
    logic [15:0] mask;
    int          cnt;
    int          first_k;
    logic [7:0]  first_dat;

    wb_rst_ni  = 1'b0;
    req_a_i    = 1'b0;  dat_a_i = 8'h00;
    req_b_i    = 1'b0;  dat_b_i = 8'h00;
    tf_count_i = 5'd0;
    flush_i    = 1'b0;
    dl_i       = 16'd0;
    dl_we_i    = 1'b0;
    repeat (3) step();
    chk("reset_outputs", 32'(all_out()), 32'h0);

    // Both requesters hold data: A first, then strict alternation every 3 cycles.
    wb_rst_ni = 1'b1;
    req_a_i = 1'b1; dat_a_i = 8'h41;
    req_b_i = 1'b1; dat_b_i = 8'h42;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 3 == 1) begin
        exp_hs = ((((k - 1) / 3) % 2) == 0) ? 4'b1101 : 4'b1011;
        chk($sformatf("rr_dat_k%0d", k), 32'(tf_dat_o), (exp_hs[2] ? 32'h41 : 32'h42));
      end else if (k % 3 == 2) begin
        exp_hs = 4'b0001;
      end else begin
        exp_hs = 4'b0000;
      end
      chk($sformatf("rr_hs_k%0d", k), 32'(hs()), 32'(exp_hs));
    end
    req_a_i = 1'b0; req_b_i = 1'b0;
    step(); step();
    chk("rr_idle", 32'(busy_o), 32'h0);

    // FIFO full: request stays pending with no push for 20 cycles.
    tf_count_i = 5'd16; req_a_i = 1'b1; dat_a_i = 8'h55;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      cnt += int'(tf_push_o) + int'(ack_a_o) + int'(busy_o);
    end
    chk("full_no_push", 32'(cnt), 32'h0);
    // Room appears; the push strobe is captured on the second edge after the drop.
    tf_count_i = 5'd15;
    step();
    chk("room_hs", 32'(hs()), 32'b1101);
    chk("room_dat", 32'(tf_dat_o), 32'h55);
    req_a_i = 1'b0; tf_count_i = 5'd0;
    step(); step();

    // Flush collides with a new B request in IDLE.
    flush_i = 1'b1; req_b_i = 1'b1; dat_b_i = 8'h42;
    step();
    chk("flush_pulse", 32'({tx_reset_o, tf_push_o, ack_a_o, ack_b_o}), 32'b1000);
    flush_i = 1'b0;
    step();
    chk("flush_done", 32'({tx_reset_o, tf_push_o, busy_o}), 32'b000);
    step();
    chk("after_flush_hs", 32'(hs()), 32'b1011);
    chk("after_flush_dat", 32'(tf_dat_o), 32'h42);
    req_b_i = 1'b0;
    step(); step();

    // Lone B wins although last grant was B; flush during PUSH replaces SETTLE.
    req_b_i = 1'b1; dat_b_i = 8'h33;
    step();
    chk("single_b_hs", 32'(hs()), 32'b1011);
    chk("single_b_dat", 32'(tf_dat_o), 32'h33);
    flush_i = 1'b1; req_b_i = 1'b0;
    step();
    chk("push_then_flush", 32'({tx_reset_o, tf_push_o, busy_o}), 32'b101);
    flush_i = 1'b0;
    step();
    chk("push_flush_idle", 32'({tx_reset_o, busy_o}), 32'b00);

    // Asynchronous reset in the middle of a PUSH.
    req_a_i = 1'b1; dat_a_i = 8'h41;
    step();
    chk("pre_abort_push", 32'(tf_push_o), 32'h1);
    wb_rst_ni = 1'b0;
    #1;
    chk("abort_outputs", 32'(all_out()), 32'h0);
    step();
    wb_rst_ni = 1'b1;
    cnt = 0; first_k = 0; first_dat = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (tf_push_o) begin
        cnt++;
        if (cnt == 1) begin
          first_k = k;
          first_dat = tf_dat_o;
        end
      end
      if (ack_a_o) req_a_i = 1'b0;
    end
    chk("abort_push_count", 32'(cnt), 32'h1);
    chk("abort_push_cycle", 32'(first_k), 32'h1);
    chk("abort_push_dat", 32'(first_dat), 32'h41);

    // Baud generator.
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      cnt += int'(enable_o);
    end
    chk("dl0_quiet", 32'(cnt), 32'h0);

    dl_i = 16'd4; dl_we_i = 1'b1;
    step();
    dl_we_i = 1'b0;
    mask = '0; mask[0] = enable_o;
    for (int k = 1; k <= 13; k++) begin
      step();
      mask[k] = enable_o;
    end
    chk("dl4_period", 32'(mask), 32'h1110);

    dl_we_i = 1'b1;
    step();
    dl_we_i = 1'b0;
    mask = '0; mask[0] = enable_o;
    for (int k = 1; k <= 13; k++) begin
      step();
      mask[k] = enable_o;
    end
    chk("dl4_rewrite", 32'(mask), 32'h1110);

    dl_i = 16'd1; dl_we_i = 1'b1;
    step();
    dl_we_i = 1'b0;
    mask = '0; mask[0] = enable_o;
    for (int k = 1; k <= 7; k++) begin
      step();
      mask[k] = enable_o;
    end
    chk("dl1_constant", 32'(mask), 32'h00FE);

    dl_i = 16'd0;
    mask = '0;
    for (int k = 0; k <= 7; k++) begin
      step();
      mask[k] = enable_o;
    end
    chk("dl0_constant", 32'(mask), 32'h0000);

    // First tick after reset release with dl=3.
    dl_i = 16'd3;
    wb_rst_ni = 1'b0;
    #1;
    chk("rst_enable", 32'(enable_o), 32'h0);
    step();
    wb_rst_ni = 1'b1;
    step();
    mask = '0; mask[0] = enable_o;
    for (int k = 1; k <= 7; k++) begin
      step();
      mask[k] = enable_o;
    end
    chk("dl3_after_reset", 32'(mask), 32'h0048);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
